uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART word/baud defaults and the arbiter state encoding.
package uart_pkg;
    localparam int WORD_SIZE  = 8;
    localparam int CLOCK_FREQ = 1_843_200;
    localparam int BAUD_RATE  = 115_200;
    typedef enum logic [1:0] {IDLE, ARM, HANDOFF, FRAME} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of one request, searching upward from last_grant+1.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] w_j;
    // Scan farthest offset first so the nearest requester after last_grant overwrites the rest.
    always_comb begin
        grant = '0;
        index = '0;
        w_j   = '0;
        for (int k = N; k >= 1; k--) begin
            w_j = IW'((int'(last_grant) + k) % N);
            if (req[w_j]) begin
                grant = N'(1) << w_j;
                index = w_j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ requesters,
// with a per-wait-state timeout that raises a sticky err.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WORD_SIZE = uart_pkg::WORD_SIZE,
    parameter int TIMEOUT   = 4 * (uart_pkg::CLOCK_FREQ / uart_pkg::BAUD_RATE) * (WORD_SIZE + 2)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [WORD_SIZE-1:0]         data_send,
    output logic                         tx_send_i,
    input  logic                         tx_avbl_i,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         err,
    input  logic                         err_clr
);
    import uart_pkg::*;
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t           r_state, w_next;
    logic [IW-1:0]        r_last, r_gid, w_idx;
    logic [NUM_REQ-1:0]   w_grant;
    logic [CW-1:0]        r_wait;
    logic [WORD_SIZE-1:0] r_data;
    logic                 r_tx, r_err, w_xfer, w_wait_st, w_tmo;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_valid),
        .last_grant(r_last),
        .grant     (w_grant),
        .index     (w_idx)
    );

    assign w_xfer    = (r_state == IDLE) && |req_valid;
    assign w_wait_st = (r_state == HANDOFF) || (r_state == FRAME);
    // A pulse arriving on the last allowed cycle still counts as progress.
    assign w_tmo     = w_wait_st && !tx_avbl_i && (r_wait == CW'(TIMEOUT - 1));

    assign req_ready = (rst_n && r_state == IDLE) ? w_grant : '0;
    assign data_send = r_data;
    assign tx_send_i = r_tx;
    assign grant_id  = r_gid;
    assign busy      = r_state != IDLE;
    assign err       = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_xfer ? ARM : IDLE;
            ARM:     w_next = HANDOFF;
            HANDOFF: w_next = tx_avbl_i ? FRAME : w_tmo ? IDLE : HANDOFF;
            FRAME:   w_next = (tx_avbl_i || w_tmo) ? IDLE : FRAME;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_gid  <= '0;
            r_last <= IW'(NUM_REQ - 1);
            r_tx   <= 1'b0;
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_data <= req_data[w_idx*WORD_SIZE +: WORD_SIZE];
                r_gid  <= w_idx;
                r_last <= w_idx;
            end
            r_tx   <= w_xfer || (r_tx && w_next == HANDOFF);
            r_wait <= (w_wait_st && w_next == r_state) ? r_wait + 1'b1 : '0;
            r_err  <= w_tmo || (r_err && !err_clr);
        end
    end
endmodule
